// File: rtl/float_div.sv
// float_div: iterative single-precision divider, radix-2 restoring, fixed 27-cycle latency
module float_div #(
  parameter int ITER = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] v1,
  input  logic [31:0] v2,
  output logic        busy,
  output logic        done,
  output logic [31:0] vres,
  output logic        div_zero
);
  typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;
  state_t state, state_nx;
  logic              s, qbit;
  logic [7:0]        e1, e2;
  logic signed [9:0] e, ex;
  logic [24:0]       r, r_sub;
  logic [23:0]       d, m_sum;
  logic [25:0]       q;
  logic [4:0]        cnt;
  logic [22:0]       m;
  logic [31:0]       res;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (start ? DIV : IDLE) :
               state == DIV  ? (cnt == 5'(ITER - 1) ? NORM : DIV) : IDLE;
  always_comb begin
    busy  = state != IDLE;
    qbit  = r >= {1'b0, d};
    r_sub = qbit ? r - {1'b0, d} : r;
    m_sum = q[25] ? {1'b0, q[24:2]} + 24'(q[1]) : {1'b0, q[23:1]} + 24'(q[0]);
    m     = m_sum[23] ? 23'h0 : m_sum[22:0];
    // Leading-zero quotient drops the exponent by one; a rounding carry bumps it back
    ex    = e + (q[25] ? 10'sd0 : -10'sd1) + (m_sum[23] ? 10'sd1 : 10'sd0);
    res   = e2 == 8'h0 ? {s, 8'hFF, 23'h0} :
            e1 == 8'h0 ? {s, 31'h0} :
            ex >= 10'sd255 ? {s, 8'hFF, 23'h0} :
            ex <= 10'sd0 ? {s, 31'h0} : {s, ex[7:0], m};
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      done     <= 1'b0;
      vres     <= 32'h0;
      div_zero <= 1'b0;
      cnt      <= 5'd0;
    end else begin
      done <= state == NORM;
      if (state == IDLE && start) begin
        s   <= v1[31] ^ v2[31];
        e1  <= v1[30:23];
        e2  <= v2[30:23];
        r   <= {2'b01, v1[22:0]};
        d   <= {1'b1, v2[22:0]};
        e   <= $signed({2'b0, v1[30:23]}) - $signed({2'b0, v2[30:23]}) + 10'sd127;
        cnt <= 5'd0;
      end else if (state == DIV) begin
        r   <= {r_sub[23:0], 1'b0};
        q   <= {q[24:0], qbit};
        cnt <= cnt + 5'd1;
      end else if (state == NORM) begin
        vres     <= res;
        div_zero <= e2 == 8'h0;
      end
    end
endmodule

// File: tb/tb_float_div.sv
// tb_float_div: directed vectors with a queue scoreboard and a done-driven monitor
module tb_float_div;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] v1 = 32'h0, v2 = 32'h0;
  logic        busy, done, div_zero;
  logic [31:0] vres;
  int          cyc = 0, compared = 0, mismatched = 0;
  typedef struct { logic [31:0] res; logic dz; int acc; } exp_t;
  exp_t sb[$];

  float_div dut (.clk(clk), .rst_n(rst_n), .start(start), .v1(v1), .v2(v2),
                 .busy(busy), .done(done), .vres(vres), .div_zero(div_zero));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk)
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done with vres %h, expected no done", vres);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("vres", vres, x.res);
        check("div_zero", 32'(div_zero), 32'(x.dz));
        check("latency", 32'(cyc - x.acc), 32'd27);
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic dz, input bit push);
    wait_idle();
    v1 = a;
    v2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{res, dz, cyc});
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] prev;
    bit got_done;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_vres", vres, 32'h0);
    check("reset_dz", 32'(div_zero), 32'd0);
    rst_n = 1'b1;

    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b1);
    check("busy_after_accept", 32'(busy), 32'd1);
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b1);
    issue(32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, 1'b1);
    issue(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b1);
    issue(32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b1);
    issue(32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 1'b1);
    issue(32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b1);
    issue(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1);
    issue(32'h3F800000, 32'h3F7FFFFF, 32'h3F800001, 1'b0, 1'b1);
    drain();

    // start held high with junk inputs while A runs; B is accepted in the done cycle
    prev = 32'h3F800001;
    wait_idle();
    v1 = 32'h40C00000;
    v2 = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{32'h40400000, 1'b0, cyc});
    got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
      else begin
        check("vres_hold", vres, prev);
        v1 = $urandom;
        v2 = $urandom;
      end
    end
    if (!got_done) check("handshake_timeout", 32'(got_done), 32'd1);
    v1 = 32'h3F800000;
    v2 = 32'h40400000;
    @(posedge clk);
    #1;
    sb.push_back('{32'h3EAAAAAB, 1'b0, cyc});
    check("b2b_busy", 32'(busy), 32'd1);
    start = 1'b0;
    drain();

    issue(32'h3F800000, 32'h40400000, 32'h0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_vres", vres, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
